// File: rtl/sys_pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package sys_pll_seq_pkg;

    localparam int RETRY_W = 8;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_FILTER    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchroniser for a single asynchronous level; resets to 0.
module lock_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync
);

    logic [1:0] r_sync;

    // Shift the raw level through two flops to settle metastability.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_sync <= '0;
        else         r_sync <= {r_sync[0], i_async};
    end

    assign o_sync = r_sync[1];

endmodule

// File: rtl/sys_pll_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a filtered lock,
// then releases per-domain resets in ascending order with a fixed gap.
// Any lock loss after release re-arms the whole sequence from the PLL reset.
module sys_pll_seq
    import sys_pll_seq_pkg::*;
#(
    parameter int CHANNELS       = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int LOCK_FILTER    = 256,
    parameter int STAGE_CYCLES   = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_locked,
    output logic               o_pll_reset,
    output logic [CHANNELS-1:0] o_rst,
    output logic               o_ready,
    output logic [RETRY_W-1:0] o_retry_cnt,
    output logic               o_lock_lost
);

    // One shared counter, wide enough that it never wraps in any state.
    localparam int MAXP  = max_int(max_int(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                   max_int(LOCK_FILTER, STAGE_CYCLES));
    localparam int CNT_W = $clog2(MAXP + 1);

    localparam logic [CNT_W-1:0] PLL_LAST   = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FILT_LAST  = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);

    logic                w_lock;
    state_t              r_state,     w_state;
    logic [CNT_W-1:0]    r_cnt,       w_cnt;
    logic                r_pll_reset, w_pll_reset;
    logic [CHANNELS-1:0] r_rst,       w_rst;
    logic                r_ready,     w_ready;
    logic [RETRY_W-1:0]  r_retry,     w_retry;
    logic                r_lost,      w_lost;
    logic [RETRY_W-1:0]  w_retry_inc;

    lock_sync u_lock_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_locked),
        .o_sync  (w_lock)
    );

    assign w_retry_inc = (r_retry == '1) ? r_retry : r_retry + RETRY_W'(1);

    // State, counter and every output are registered together.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_PLL_RST;
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            r_rst       <= '1;
            r_ready     <= 1'b0;
            r_retry     <= '0;
            r_lost      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_pll_reset <= w_pll_reset;
            r_rst       <= w_rst;
            r_ready     <= w_ready;
            r_retry     <= w_retry;
            r_lost      <= w_lost;
        end
    end

    // Next-state and next-output logic. Releases shift a zero in from bit 0,
    // so o_rst is always ones above the released channels: order is ascending
    // by construction and a reload of all-ones restarts from channel 0.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_pll_reset = r_pll_reset;
        w_rst       = r_rst;
        w_ready     = r_ready;
        w_retry     = r_retry;
        w_lost      = r_lost;
        case (r_state)
            ST_PLL_RST: begin
                w_pll_reset = 1'b1;
                w_rst       = '1;
                w_ready     = 1'b0;
                if (r_cnt == PLL_LAST) begin
                    w_state     = ST_WAIT_LOCK;
                    w_cnt       = '0;
                    w_pll_reset = 1'b0;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (w_lock) begin
                    w_state = ST_FILTER;
                    w_cnt   = '0;
                end else if (r_cnt == TO_LAST) begin
                    w_state     = ST_PLL_RST;
                    w_cnt       = '0;
                    w_pll_reset = 1'b1;
                    w_retry     = w_retry_inc;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            ST_FILTER: begin
                if (!w_lock) begin
                    w_state = ST_WAIT_LOCK;
                    w_cnt   = '0;
                end else if (r_cnt == FILT_LAST) begin
                    w_state = ST_RELEASE;
                    w_cnt   = '0;
                    w_rst   = r_rst << 1;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            ST_RELEASE, ST_RUN: begin
                if (!w_lock) begin
                    w_state     = ST_PLL_RST;
                    w_cnt       = '0;
                    w_pll_reset = 1'b1;
                    w_rst       = '1;
                    w_ready     = 1'b0;
                    w_lost      = 1'b1;
                    w_retry     = w_retry_inc;
                end else if (r_state == ST_RELEASE) begin
                    if (r_rst == '0) begin
                        w_state = ST_RUN;
                        w_ready = 1'b1;
                    end else if (r_cnt == STAGE_LAST) begin
                        w_rst = r_rst << 1;
                        w_cnt = '0;
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state     = ST_PLL_RST;
                w_cnt       = '0;
                w_pll_reset = 1'b1;
                w_rst       = '1;
                w_ready     = 1'b0;
            end
        endcase
    end

    assign o_pll_reset = r_pll_reset;
    assign o_rst       = r_rst;
    assign o_ready     = r_ready;
    assign o_retry_cnt = r_retry;
    assign o_lock_lost = r_lost;

endmodule

// File: tb/tb_sys_pll_seq.sv
// Directed bench for sys_pll_seq: a 3-channel build and a 1-channel build
// driven by the same reset and lock inputs.
module tb_sys_pll_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       locked;
    logic       pll_reset, ready, lost;
    logic [2:0] rst_o;
    logic [7:0] retry;
    logic       d1_pll_reset, d1_ready, d1_lost;
    logic [0:0] d1_rst;
    logic [7:0] d1_retry;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sys_pll_seq #(.CHANNELS(3), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20),
                  .LOCK_FILTER(8), .STAGE_CYCLES(5)) dut (
        .i_clk(clk), .i_reset(rst), .i_locked(locked),
        .o_pll_reset(pll_reset), .o_rst(rst_o), .o_ready(ready),
        .o_retry_cnt(retry), .o_lock_lost(lost)
    );

    sys_pll_seq #(.CHANNELS(1), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20),
                  .LOCK_FILTER(8), .STAGE_CYCLES(5)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_locked(locked),
        .o_pll_reset(d1_pll_reset), .o_rst(d1_rst), .o_ready(d1_ready),
        .o_retry_cnt(d1_retry), .o_lock_lost(d1_lost)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pll_fall(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (pll_reset && n < 100);
    endtask

    // Cycle numbers are counted from the edge after the last input change.
    task automatic run_seq(input int ncyc, output int t0, output int t1,
                           output int t2, output int tr, output int d0, output int dr);
        t0 = 999; t1 = 999; t2 = 999; tr = 999; d0 = 999; dr = 999;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            if (t0 == 999 && !rst_o[0]) t0 = c;
            if (t1 == 999 && !rst_o[1]) t1 = c;
            if (t2 == 999 && !rst_o[2]) t2 = c;
            if (tr == 999 && ready)     tr = c;
            if (d0 == 999 && !d1_rst[0]) d0 = c;
            if (dr == 999 && d1_ready)   dr = c;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, t0, t1, t2, tr, d0, dr;
        int t_rst, t_rdy, t_rise, t_fall, t_glitch, rises;
        logic prev, bad;

        // Reset state
        rst = 1'b1; locked = 1'b0;
        repeat (3) tick();
        chk("rst_pll_reset", pll_reset, 1);
        chk("rst_o_rst",     rst_o, 3'b111);
        chk("rst_ready",     ready, 0);
        chk("rst_retry",     retry, 0);
        chk("rst_lost",      lost, 0);
        rst = 1'b0;
        wait_pll_fall(n);
        chk("first_pll_pulse", n, 4);

        // Nominal: lock rises 10 cycles after the PLL reset falls
        repeat (10) tick();
        locked = 1'b1;
        run_seq(30, t0, t1, t2, tr, d0, dr);
        chk("nom_rst0_fall", t0, 11);
        chk("nom_rst1_fall", t1, 16);
        chk("nom_rst2_fall", t2, 21);
        chk("nom_ready",     tr, 22);
        chk("nom_retry",     retry, 0);
        chk("ch1_rst0_fall", d0, 11);
        chk("ch1_ready",     dr, 12);

        // Lock loss in RUN
        locked = 1'b0;
        t_rst = 999; t_rdy = 999; t_rise = 999; t_fall = 999;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (t_rst == 999 && rst_o == 3'b111) t_rst = c;
            if (t_rdy == 999 && !ready) t_rdy = c;
            if (t_rise == 999 && pll_reset) t_rise = c;
            if (t_rise != 999 && t_fall == 999 && !pll_reset) t_fall = c;
        end
        chk("loss_rst_lat",   t_rst, 3);
        chk("loss_ready_lat", t_rdy, 3);
        chk("loss_pll_rise",  t_rise, 3);
        chk("loss_pll_fall",  t_fall, 7);
        chk("loss_lost",      lost, 1);
        chk("loss_retry",     retry, 1);

        // Relock: full re-sequence from channel 0, stop between rst[1] and rst[2]
        locked = 1'b1;
        run_seq(18, t0, t1, t2, tr, d0, dr);
        chk("reseq_rst0_fall", t0, 11);
        chk("reseq_rst1_fall", t1, 16);
        chk("reseq_rst_mid",   rst_o, 3'b100);

        // Asynchronous reset mid-RELEASE takes effect before any edge
        #2 rst = 1'b1;
        #1;
        chk("arst_o_rst",     rst_o, 3'b111);
        chk("arst_pll_reset", pll_reset, 1);
        chk("arst_ready",     ready, 0);
        chk("arst_lost",      lost, 0);
        chk("arst_retry",     retry, 0);
        locked = 1'b0;
        tick(); tick();
        rst = 1'b0;
        wait_pll_fall(n);
        chk("arst_pll_pulse", n, 4);

        // Lock glitch of 5 cycles: no release, retry 20 cycles after the
        // synchronised drop reaches WAIT_LOCK (2 sync + 1 register)
        repeat (3) tick();
        locked = 1'b1;
        repeat (5) tick();
        locked = 1'b0;
        bad = 1'b0; t_glitch = 999;
        for (int c = 1; c <= 40 && t_glitch == 999; c++) begin
            tick();
            if (rst_o != 3'b111) bad = 1'b1;
            if (pll_reset) t_glitch = c;
        end
        chk("glitch_no_release", bad, 0);
        chk("glitch_retry_time", t_glitch, 23);
        chk("glitch_retry_cnt",  retry, 1);

        // No lock: 4-cycle pulses every 20 cycles
        wait_pll_fall(n);
        chk("to_pll_pulse", n, 4);
        n = 0;
        do begin tick(); n++; end while (!pll_reset && n < 100);
        chk("to_gap", n, 20);
        chk("to_retry_cnt", retry, 2);

        // Saturation after 300 more timeouts
        rises = 0; prev = pll_reset;
        for (int c = 0; c < 8000 && rises < 300; c++) begin
            tick();
            if (pll_reset && !prev) rises++;
            prev = pll_reset;
        end
        chk("sat_rises", rises, 300);
        chk("sat_retry", retry, 255);
        chk("sat_o_rst", rst_o, 3'b111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
